// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch slice: the NOP used as the
// idle decode word, the default reset PC, the queue entry layout and the
// sequential PC step.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered instruction together with the address it came from
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    // Sequential PC step; wraps from 0xFFFF_FFFC back to 0
    function automatic logic [31:0] nextPc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit_if
// Bundles the fetch unit's instruction-memory, redirect and decode signals.
//   master : the fetch unit (drives memory requests and decode outputs)
//   slave  : the environment (memory, execute redirect, decode)
// Signals:
//   oImem_Req/oImem_Addr      request and address to instruction memory
//   iImem_Gnt                 memory accepts the request this cycle
//   iImem_Rvalid/iImem_Rdata  in-order response word
//   iRedirect/iRedirect_PC    taken branch/jump and its target
//   oInst_Valid/Code/PC       head instruction presented to decode
//   iInst_Ready               decode consumes the head this cycle
// ---------------------------------------------------------------------------
interface inst_fetch_unit_if;

    logic        oImem_Req;
    logic [31:0] oImem_Addr;
    logic        iImem_Gnt;
    logic        iImem_Rvalid;
    logic [31:0] iImem_Rdata;
    logic        iRedirect;
    logic [31:0] iRedirect_PC;
    logic        oInst_Valid;
    logic [31:0] oInst_Code;
    logic [31:0] oInst_PC;
    logic        iInst_Ready;

    modport master (
        output oImem_Req, oImem_Addr,
        input  iImem_Gnt, iImem_Rvalid, iImem_Rdata,
        input  iRedirect, iRedirect_PC,
        output oInst_Valid, oInst_Code, oInst_PC,
        input  iInst_Ready
    );

    modport slave (
        input  oImem_Req, oImem_Addr,
        output iImem_Gnt, iImem_Rvalid, iImem_Rdata,
        output iRedirect, iRedirect_PC,
        input  oInst_Valid, oInst_Code, oInst_PC,
        output iInst_Ready
    );

endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Small synchronous FIFO of fetch entries between the memory response path
// and decode.
// Ports:
//   iClk, iRst        clock, asynchronous active-high reset
//   push, pushEntry   write an entry at the tail
//   pop               remove the head entry (ignored when empty)
//   flush             discard every entry; overrides push and pop
//   headEntry         entry at the head (meaningless when empty)
//   empty, full       occupancy flags
//   count             number of stored entries
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  fetch_entry_t              pushEntry,
    output fetch_entry_t              headEntry,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(QDEPTH):0]   count
);

    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(QDEPTH);

    fetch_entry_t  mem [QDEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic          doPush;
    logic          doPop;

    assign doPush    = push && !flush;
    assign doPop     = pop && !empty && !flush;
    assign empty     = (count == '0);
    assign full      = (count == DEPTH_CNT);
    assign headEntry = mem[rdPtr];

    // Pointer and occupancy bookkeeping. Depth is a power of two, so the
    // pointers wrap on their own. A flush simply rewinds everything.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            unique case ({doPush, doPop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge iClk) begin
        if (doPush) begin
            mem[wrPtr] <= pushEntry;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
// RV32I fetch stage. Issues in-order requests to instruction memory, buffers
// returned words in fetch_queue and hands them to decode. A redirect flushes
// the queue and marks every in-flight request stale so its word is dropped.
// Ports:
//   iClk, iRst   clock, asynchronous active-high reset
//   bus          inst_fetch_unit_if.master (memory, redirect, decode)
// ---------------------------------------------------------------------------
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic               iClk,
    input  logic               iRst,
    inst_fetch_unit_if.master  bus
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int SW = $clog2(2 * QDEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [SW-1:0] STALE_ONE    = SW'(1);
    localparam logic [CW:0]   CREDIT_LIMIT = (CW+1)'(QDEPTH);

    logic [31:0]   fetchPc;
    logic [31:0]   respPc;
    logic [31:0]   lastPc;
    logic [31:0]   redirectPc;
    logic [1:0]    unusedPcBits;
    logic [CW-1:0] liveCount;
    logic [CW-1:0] queueCount;
    logic [SW-1:0] staleCount;
    logic [CW:0]   effCount;
    logic [CW:0]   inFlight;
    logic          reqFire;
    logic          respAccept;
    logic          popHead;
    logic          queueEmpty;
    logic          queueFull;
    fetch_entry_t  pushEntry;
    fetch_entry_t  headEntry;

    assign redirectPc   = {bus.iRedirect_PC[31:2], 2'b00};
    assign unusedPcBits = bus.iRedirect_PC[1:0];

    // Credit check: queue occupancy after this cycle's pop plus requests
    // still owed a response may not reach the queue depth. Counting the pop
    // lets a new request go out in the same cycle decode drains an entry,
    // which is what sustains one instruction per cycle at latency 1.
    assign popHead  = !queueEmpty && bus.iInst_Ready;
    assign effCount = {1'b0, queueCount} - {{CW{1'b0}}, popHead};
    assign inFlight = effCount + {1'b0, liveCount};

    assign bus.oImem_Req  = !iRst && !bus.iRedirect && (inFlight < CREDIT_LIMIT);
    assign bus.oImem_Addr = fetchPc;
    assign reqFire        = bus.oImem_Req && bus.iImem_Gnt;

    // A response is kept only when no stale words are still owed and no
    // redirect is discarding this cycle's traffic.
    assign respAccept = bus.iImem_Rvalid && !bus.iRedirect && (staleCount == '0);
    assign pushEntry  = '{inst: bus.iImem_Rdata, pc: respPc};

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) queue (
        .iClk      (iClk),
        .iRst      (iRst),
        .push      (respAccept),
        .pop       (popHead),
        .flush     (bus.iRedirect),
        .pushEntry (pushEntry),
        .headEntry (headEntry),
        .empty     (queueEmpty),
        .full      (queueFull),
        .count     (queueCount)
    );

    // PC tracking plus outstanding/stale accounting. On a redirect every live
    // request becomes stale; a response landing in the redirect cycle settles
    // one of those requests immediately, so it is not carried into stale.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            fetchPc    <= RESET_PC;
            respPc     <= RESET_PC;
            liveCount  <= '0;
            staleCount <= '0;
        end else if (bus.iRedirect) begin
            fetchPc    <= redirectPc;
            respPc     <= redirectPc;
            liveCount  <= '0;
            staleCount <= staleCount + SW'(liveCount)
                          - (bus.iImem_Rvalid ? STALE_ONE : '0);
        end else begin
            if (reqFire) begin
                fetchPc <= nextPc(fetchPc);
            end
            if (respAccept) begin
                respPc <= nextPc(respPc);
            end
            if (bus.iImem_Rvalid && (staleCount != '0)) begin
                staleCount <= staleCount - STALE_ONE;
            end
            unique case ({reqFire, respAccept})
                2'b10:   liveCount <= liveCount + CNT_ONE;
                2'b01:   liveCount <= liveCount - CNT_ONE;
                default: liveCount <= liveCount;
            endcase
        end
    end

    // Remember the PC last shown to decode so it can be held while the
    // queue is empty.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            lastPc <= RESET_PC;
        end else if (!queueEmpty) begin
            lastPc <= headEntry.pc;
        end
    end

    assign bus.oInst_Valid = !queueEmpty;
    assign bus.oInst_Code  = queueEmpty ? NOP_INST : headEntry.inst;
    assign bus.oInst_PC    = queueEmpty ? lastPc   : headEntry.pc;

    // The credit check makes a push into a full queue impossible.
    assert property (@(posedge iClk) disable iff (iRst) !(respAccept && queueFull));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
// Directed bench for inst_fetch_unit. A small in-order memory responder
// returns {16'hC0DE, addr[15:0]} a configurable number of cycles after each
// grant; the main sequence drives grant/ready/redirect/reset and compares
// outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   errorCount = 0;
    int   memLatency = 1;
    int   cycleNum   = 0;

    logic [31:0] pendAddr[$];
    int          pendDue[$];

    inst_fetch_unit_if bus();

    inst_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {16'hC0DE, addr[15:0]};
    endfunction

    // Memory responder: at each falling edge decide this cycle's response,
    // then record a grant if one is happening. Reset empties the memory.
    initial begin
        bus.iImem_Rvalid = 1'b0;
        bus.iImem_Rdata  = 32'h0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                pendAddr.delete();
                pendDue.delete();
                bus.iImem_Rvalid = 1'b0;
                bus.iImem_Rdata  = 32'h0;
            end else begin
                cycleNum++;
                if (pendDue.size() > 0 && pendDue[0] == cycleNum) begin
                    bus.iImem_Rvalid = 1'b1;
                    bus.iImem_Rdata  = memWord(pendAddr[0]);
                    void'(pendAddr.pop_front());
                    void'(pendDue.pop_front());
                end else begin
                    bus.iImem_Rvalid = 1'b0;
                end
                if (bus.oImem_Req && bus.iImem_Gnt) begin
                    pendAddr.push_back(bus.oImem_Addr);
                    pendDue.push_back(cycleNum + memLatency);
                end
            end
        end
    end

    task automatic applyStimulus(input logic gnt, input logic ready,
                                 input logic redirect, input logic [31:0] redirectPc);
        bus.iImem_Gnt    = gnt;
        bus.iInst_Ready  = ready;
        bus.iRedirect    = redirect;
        bus.iRedirect_PC = redirectPc;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
    endtask

    // Directed sequence: settle inputs two time units after a rising edge,
    // wait one more unit, then compare.
    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        $display("[TB] reset state");
        checkOutput("resetValid", 32'(bus.oInst_Valid), 32'd0);
        checkOutput("resetCode",  bus.oInst_Code,       32'h0000_0013);
        checkOutput("resetPc",    bus.oInst_PC,         32'h0000_0000);
        checkOutput("resetReq",   32'(bus.oImem_Req),   32'd0);

        // Latency 1, ready high: stream 0x0, 0x4, 0x8 ...
        $display("[TB] streaming at latency 1");
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("c1Req",  32'(bus.oImem_Req), 32'd1);
        checkOutput("c1Addr", bus.oImem_Addr,     32'h0);
        nextCycle(); #1;
        checkOutput("c2Addr",  bus.oImem_Addr,       32'h4);
        checkOutput("c2Valid", 32'(bus.oInst_Valid), 32'd0);
        nextCycle(); #1;
        checkOutput("c3Valid", 32'(bus.oInst_Valid), 32'd1);
        checkOutput("c3Pc",    bus.oInst_PC,         32'h0);
        checkOutput("c3Code",  bus.oInst_Code,       32'hC0DE_0000);
        checkOutput("c3Addr",  bus.oImem_Addr,       32'h8);
        nextCycle(); #1;
        checkOutput("c4Pc",   bus.oInst_PC,   32'h4);
        checkOutput("c4Code", bus.oInst_Code, 32'hC0DE_0004);
        checkOutput("c4Addr", bus.oImem_Addr, 32'hC);

        // Ready low: queue fills, request drops and stays low
        $display("[TB] decode stall");
        nextCycle();
        bus.iInst_Ready = 1'b0;
        #1;
        checkOutput("c5Pc",  bus.oInst_PC,        32'h8);
        checkOutput("c5Req", 32'(bus.oImem_Req),  32'd0);
        nextCycle(); #1;
        checkOutput("c6Req", 32'(bus.oImem_Req),  32'd0);
        checkOutput("c6Pc",  bus.oInst_PC,        32'h8);
        nextCycle(); #1;
        checkOutput("c7Req", 32'(bus.oImem_Req),  32'd0);
        nextCycle();
        bus.iInst_Ready = 1'b1;
        #1;
        checkOutput("c8Pc",   bus.oInst_PC,       32'h8);
        checkOutput("c8Req",  32'(bus.oImem_Req), 32'd1);
        checkOutput("c8Addr", bus.oImem_Addr,     32'h10);
        nextCycle(); #1;
        checkOutput("c9Pc",  bus.oInst_PC, 32'hC);
        nextCycle(); #1;
        checkOutput("c10Pc", bus.oInst_PC, 32'h10);
        nextCycle(); #1;
        checkOutput("c11Pc", bus.oInst_PC, 32'h14);
        checkOutput("c11Valid", 32'(bus.oInst_Valid), 32'd1);

        // Asynchronous reset between edges, then grant withheld
        $display("[TB] mid-stream reset and grant stall");
        nextCycle();
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arstValid", 32'(bus.oInst_Valid), 32'd0);
        checkOutput("arstCode",  bus.oInst_Code,       32'h0000_0013);
        checkOutput("arstPc",    bus.oInst_PC,         32'h0);
        checkOutput("arstReq",   32'(bus.oImem_Req),   32'd0);
        bus.iImem_Gnt = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("relReq",  32'(bus.oImem_Req), 32'd1);
        checkOutput("relAddr", bus.oImem_Addr,     32'h0);
        checkOutput("relCode", bus.oInst_Code,     32'h0000_0013);
        nextCycle();
        bus.iImem_Gnt = 1'b1;
        #1;
        checkOutput("d1Addr", bus.oImem_Addr, 32'h0);
        nextCycle();
        bus.iImem_Gnt = 1'b0;
        #1;
        checkOutput("d2Req",  32'(bus.oImem_Req), 32'd1);
        checkOutput("d2Addr", bus.oImem_Addr,     32'h4);
        nextCycle(); #1;
        checkOutput("d3Addr", bus.oImem_Addr, 32'h4);
        checkOutput("d3Pc",   bus.oInst_PC,   32'h0);
        checkOutput("d3Code", bus.oInst_Code, 32'hC0DE_0000);
        nextCycle(); #1;
        checkOutput("d4Req",   32'(bus.oImem_Req),   32'd1);
        checkOutput("d4Addr",  bus.oImem_Addr,       32'h4);
        checkOutput("d4Valid", 32'(bus.oInst_Valid), 32'd0);
        checkOutput("d4Code",  bus.oInst_Code,       32'h0000_0013);
        nextCycle();
        bus.iImem_Gnt = 1'b1;
        #1;
        checkOutput("d5Addr", bus.oImem_Addr, 32'h4);
        nextCycle();
        bus.iImem_Gnt = 1'b0;
        #1;
        checkOutput("d6Addr", bus.oImem_Addr, 32'h8);

        // Latency 3, two outstanding, redirect to 0x100
        $display("[TB] redirect with stale responses in flight");
        doReset();
        memLatency = 3;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("e1Addr", bus.oImem_Addr, 32'h0);
        nextCycle(); #1;
        checkOutput("e2Addr", bus.oImem_Addr, 32'h4);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        #1;
        checkOutput("e3Req", 32'(bus.oImem_Req), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("e4Req",   32'(bus.oImem_Req),   32'd1);
        checkOutput("e4Addr",  bus.oImem_Addr,       32'h100);
        checkOutput("e4Valid", 32'(bus.oInst_Valid), 32'd0);
        nextCycle(); #1;
        checkOutput("e5Valid", 32'(bus.oInst_Valid), 32'd0);
        checkOutput("e5Addr",  bus.oImem_Addr,       32'h104);
        nextCycle(); #1;
        checkOutput("e6Valid", 32'(bus.oInst_Valid), 32'd0);
        checkOutput("e6Req",   32'(bus.oImem_Req),   32'd0);
        nextCycle(); #1;
        checkOutput("e7Valid", 32'(bus.oInst_Valid), 32'd0);
        nextCycle(); #1;
        checkOutput("e8Valid", 32'(bus.oInst_Valid), 32'd1);
        checkOutput("e8Pc",    bus.oInst_PC,         32'h100);
        checkOutput("e8Code",  bus.oInst_Code,       32'hC0DE_0100);
        nextCycle(); #1;
        checkOutput("e9Pc",   bus.oInst_PC,   32'h104);
        checkOutput("e9Code", bus.oInst_Code, 32'hC0DE_0104);
        nextCycle(); #1;
        checkOutput("e10Valid", 32'(bus.oInst_Valid), 32'd0);
        checkOutput("e10Code",  bus.oInst_Code,       32'h0000_0013);
        checkOutput("e10Pc",    bus.oInst_PC,         32'h104);

        // Redirect to 0x203 in the same cycle as a response
        $display("[TB] redirect colliding with a response");
        doReset();
        memLatency = 1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("f1Addr", bus.oImem_Addr, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0203);
        #1;
        checkOutput("f2Req", 32'(bus.oImem_Req), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("f3Req",   32'(bus.oImem_Req),   32'd1);
        checkOutput("f3Addr",  bus.oImem_Addr,       32'h200);
        checkOutput("f3Valid", 32'(bus.oInst_Valid), 32'd0);
        nextCycle(); #1;
        checkOutput("f4Valid", 32'(bus.oInst_Valid), 32'd0);
        checkOutput("f4Addr",  bus.oImem_Addr,       32'h204);
        nextCycle(); #1;
        checkOutput("f5Valid", 32'(bus.oInst_Valid), 32'd1);
        checkOutput("f5Pc",    bus.oInst_PC,         32'h200);
        checkOutput("f5Code",  bus.oInst_Code,       32'hC0DE_0200);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
